lsu_mem_stage: RTL and testbench

- Load/store stage directly downstream of the ALU. Takes the ALU result as the effective address and the second register operand as store data.
- Issues one request at a time on a simple grant/rvalid data-memory bus.
- Returns a single-cycle response with aligned, sign/zero-extended load data, or an error flag.
- Sits between execute and writeback in the reduced RISC-V core.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_mem_stage_lane.sv | 47 ++++
 rtl/lsu_mem_stage.sv | 147 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory stage.
// Sizes, FSM states, byte-enable patterns and the timeout counter width.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } state_e;

    localparam logic [3:0] BE_B   = 4'b0001;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    // Illegal size (2'b11) or an address not naturally aligned to the access size.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] a);
        return (size == 2'b11) ||
               ((size == SZ_H) && a[0]) ||
               ((size == SZ_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_stage_lane.sv
// Byte-lane steering: store replication and byte enables, load lane
// extraction with sign/zero extension. Purely combinational.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign ld_b = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign ld_h = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        be_o    = BE_W;
        wdata_o = wdata_i;
        case (size_i)
            SZ_B: begin
                be_o    = BE_B << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                be_o    = addr_lo_i[1] ? BE_HHI : BE_HLO;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_o = rdata_i;
        case (size_i)
            SZ_B: rdata_o = {{24{ld_b[7]  & ~unsigned_i}}, ld_b};
            SZ_H: rdata_o = {{16{ld_h[15] & ~unsigned_i}}, ld_h};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: one outstanding op on a grant/rvalid memory bus,
// single-cycle response with extended load data or an error flag.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [D_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               resp_valid,
    output logic [D_WIDTH-1:0] resp_rdata,
    output logic               resp_err,
    output logic               mem_req,
    output logic               mem_we,
    output logic [D_WIDTH-1:0] mem_addr,
    output logic [3:0]         mem_be,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [D_WIDTH-1:0] mem_rdata
);

    localparam int CW = cnt_width(TIMEOUT);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [D_WIDTH-1:0] addr_q, addr_d;
    logic [D_WIDTH-1:0] wdata_q, wdata_d;
    logic [D_WIDTH-1:0] rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               timeout;
    logic               in_req;
    logic [3:0]         lane_be;
    logic [D_WIDTH-1:0] lane_wdata;
    logic [D_WIDTH-1:0] lane_rdata;

    lsu_lane u_lane (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .addr_lo_i  (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata)
    );

    // Counter never passes TIMEOUT: it stops incrementing once the limit is hit.
    assign timeout = (cnt_q >= CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = req_bad(req_size, req_addr[1:0]);
                    state_d = req_bad(req_size, req_addr[1:0]) ? RESP : REQ;
                end
            end
            REQ: begin
                if (!timeout) cnt_d = cnt_q + CW'(1);
                if (mem_gnt) begin
                    state_d = we_q ? RESP : WAIT;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (!timeout) cnt_d = cnt_q + CW'(1);
                if (mem_rvalid) begin
                    rdata_d = lane_rdata;
                    state_d = RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus fields are driven from captured state only while requesting.
    assign in_req     = (state_q == REQ);
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;
    assign mem_req    = in_req;
    assign mem_we     = in_req & we_q;
    assign mem_addr   = in_req ? {addr_q[D_WIDTH-1:2], 2'b00} : '0;
    assign mem_be     = in_req ? lane_be : 4'b0000;
    assign mem_wdata  = in_req ? lane_wdata : '0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed scenarios plus randomized
// ops compared against a behavioural model of addressing, lanes and timing.
module tb_lsu_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.D_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    // ---------------- reference model ----------------
    function automatic logic m_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] one;
        one = 32'd1;
        if (sz == 2'd0) return 4'(one << (a % 4));
        if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] mask, v;
        int bits, sh;
        if (sz == 2'd2) return rd;
        bits = (sz == 2'd0) ? 8 : 16;
        sh   = (sz == 2'd0) ? int'(a % 4) * 8 : (((a % 4) >= 2) ? 16 : 0);
        mask = (32'd1 << bits) - 32'd1;
        v    = (rd >> sh) & mask;
        if (!uns && (((v >> (bits - 1)) & 32'd1) != 0)) v = v | ~mask;
        return v;
    endfunction

    // ---------------- driver / memory responder ----------------
    // gd: REQ cycles to wait before granting (grant on REQ cycle gd+1).
    // rdl: WAIT cycles to wait before rvalid. Returns observations only.
    task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int gd, input int rdl,
                          output int lat, output logic [31:0] o_rdata, output logic o_err,
                          output int nreq, output logic [31:0] o_addr, output logic [31:0] o_wdata,
                          output logic [3:0] o_be, output logic o_we, output logic stable);
        logic granted;
        int wc;
        lat = -1; o_rdata = '0; o_err = 1'b0; nreq = 0; stable = 1'b1; granted = 1'b0; wc = 0;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (resp_valid) begin
                lat = cyc; o_rdata = resp_rdata; o_err = resp_err;
                break;
            end
            if (mem_req) begin
                nreq++;
                if (nreq == 1) begin
                    o_addr = mem_addr; o_wdata = mem_wdata; o_be = mem_be; o_we = mem_we;
                end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                             mem_be !== o_be || mem_we !== o_we) begin
                    stable = 1'b0;
                end
                if (nreq > gd) begin mem_gnt = 1'b1; granted = 1'b1; end
                mem_rvalid = 1'($urandom);
            end else if (granted) begin
                wc++;
                if (wc > rdl) begin mem_rvalid = 1'b1; mem_rdata = rd; end
            end
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        n_chk++; if ({resp_valid, resp_err, mem_req, mem_we} !== 4'b0) begin n_fail++; $display("FAIL rst_ctl: got %b want 0000", {resp_valid, resp_err, mem_req, mem_we}); end
        n_chk++; if ({resp_rdata, mem_addr, mem_wdata, mem_be} !== '0) begin n_fail++; $display("FAIL rst_data: rdata %h addr %h wdata %h be %h want 0", resp_rdata, mem_addr, mem_wdata, mem_be); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_store();
        int lat, nreq; logic [31:0] rdv, a, w; logic err, we, st; logic [3:0] be;
        run_op(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, lat, rdv, err, nreq, a, w, be, we, st);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL ws_lat: got %0d want 2", lat); end
        n_chk++; if (a !== 32'h104 || be !== 4'hF || w !== 32'hDEADBEEF || we !== 1'b1) begin n_fail++; $display("FAIL ws_bus: addr %h be %h wdata %h we %b", a, be, w, we); end
        n_chk++; if (err !== 1'b0 || rdv !== 32'h0) begin n_fail++; $display("FAIL ws_resp: err %b rdata %h want 0/0", err, rdv); end
        @(posedge clk); #1;
        n_chk++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL ws_idle: ready %b resp %b", req_ready, resp_valid); end
    endtask

    task automatic test_byte_load();
        int lat, nreq; logic [31:0] rdv, a, w; logic err, we, st; logic [3:0] be;
        run_op(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80123456, 0, 0, lat, rdv, err, nreq, a, w, be, we, st);
        n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL lb_lat: got %0d want 3", lat); end
        n_chk++; if (rdv !== 32'hFFFFFF80 || err !== 1'b0) begin n_fail++; $display("FAIL lb_data: got %h err %b want ffffff80", rdv, err); end
        n_chk++; if (a !== 32'h200 || be !== 4'b1000 || we !== 1'b0) begin n_fail++; $display("FAIL lb_bus: addr %h be %b we %b", a, be, we); end
        @(posedge clk); #1;
        run_op(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80123456, 0, 0, lat, rdv, err, nreq, a, w, be, we, st);
        n_chk++; if (rdv !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h want 00000080", rdv); end
        @(posedge clk); #1;
    endtask

    task automatic test_half_store_delayed();
        int lat, nreq; logic [31:0] rdv, a, w; logic err, we, st; logic [3:0] be;
        run_op(1'b1, 2'b01, 1'b0, 32'h06, 32'h0000ABCD, 32'h0, 3, 0, lat, rdv, err, nreq, a, w, be, we, st);
        n_chk++; if (a !== 32'h04 || w !== 32'hABCDABCD || be !== 4'b1100) begin n_fail++; $display("FAIL hs_bus: addr %h wdata %h be %b", a, w, be); end
        n_chk++; if (nreq !== 4 || st !== 1'b1) begin n_fail++; $display("FAIL hs_hold: req cycles %0d stable %b want 4/1", nreq, st); end
        n_chk++; if (lat !== 5 || err !== 1'b0) begin n_fail++; $display("FAIL hs_lat: got %0d err %b want 5/0", lat, err); end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        int lat, nreq; logic [31:0] rdv, a, w; logic err, we, st; logic [3:0] be;
        run_op(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h12345678, 0, 0, lat, rdv, err, nreq, a, w, be, we, st);
        n_chk++; if (lat !== 1 || err !== 1'b1 || rdv !== 32'h0) begin n_fail++; $display("FAIL mis_resp: lat %0d err %b rdata %h want 1/1/0", lat, err, rdv); end
        n_chk++; if (nreq !== 0) begin n_fail++; $display("FAIL mis_noreq: got %0d req cycles want 0", nreq); end
        @(posedge clk); #1;
        run_op(1'b1, 2'b11, 1'b0, 32'h40, 32'h5, 32'h0, 0, 0, lat, rdv, err, nreq, a, w, be, we, st);
        n_chk++; if (lat !== 1 || err !== 1'b1 || nreq !== 0) begin n_fail++; $display("FAIL ill_resp: lat %0d err %b req %0d want 1/1/0", lat, err, nreq); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int lat, nreq; logic [31:0] rdv, a, w; logic err, we, st; logic [3:0] be;
        run_op(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0, 99, 0, lat, rdv, err, nreq, a, w, be, we, st);
        n_chk++; if (nreq !== TO || lat !== TO + 1) begin n_fail++; $display("FAIL to_lat: req %0d lat %0d want %0d/%0d", nreq, lat, TO, TO + 1); end
        n_chk++; if (err !== 1'b1 || rdv !== 32'h0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL to_resp: err %b rdata %h mem_req %b", err, rdv, mem_req); end
        @(posedge clk); #1;
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_reset_wait();
        int lat, nreq; logic [31:0] rdv, a, w; logic err, we, st; logic [3:0] be;
        logic seen;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        n_chk++; if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rw_wait: req %b resp %b ready %b", mem_req, resp_valid, req_ready); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        n_chk++; if (req_ready !== 1'b1 || {resp_valid, resp_err, mem_req, mem_we} !== 4'b0 || {resp_rdata, mem_addr, mem_wdata, mem_be} !== '0) begin n_fail++; $display("FAIL rw_outs: ready %b ctl %b rdata %h addr %h", req_ready, {resp_valid, resp_err, mem_req, mem_we}, resp_rdata, mem_addr); end
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            if (resp_valid) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rw_noresp: got resp_valid %b want 0", seen); end
        run_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h9876_5432, 1, 1, lat, rdv, err, nreq, a, w, be, we, st);
        n_chk++; if (lat !== 5 || err !== 1'b0 || rdv !== 32'h00009876) begin n_fail++; $display("FAIL rw_next: lat %0d err %b rdata %h want 5/0/00009876", lat, err, rdv); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, nreq, g, gd, rdl, elat, ereq;
        logic [31:0] rdv, a, w, addr, wd, rd, erd;
        logic err, we, st, rwe, uns, bad, eerr;
        logic [3:0] be;
        logic [1:0] sz;
        for (int i = 0; i < 60; i++) begin
            rwe = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
            addr = $urandom; wd = $urandom; rd = $urandom;
            gd = $urandom_range(0, 4); rdl = $urandom_range(0, 4);
            if ($urandom_range(0, 9) == 0) gd = 20;
            if ($urandom_range(0, 2) != 0) addr = addr & ~((sz == 2'd1) ? 32'd1 : (sz == 2'd2) ? 32'd3 : 32'd0);
            run_op(rwe, sz, uns, addr, wd, rd, gd, rdl, lat, rdv, err, nreq, a, w, be, we, st);
            bad = m_bad(sz, addr); g = gd + 1; erd = 32'h0;
            ereq = bad ? 0 : ((g < TO) ? g : TO);
            if (bad) begin elat = 1; eerr = 1'b1; end
            else if (g > TO) begin elat = TO + 1; eerr = 1'b1; end
            else if (rwe) begin elat = g + 1; eerr = 1'b0; end
            else if (g + rdl + 1 <= TO || rdl == 0) begin elat = g + rdl + 2; eerr = 1'b0; erd = m_ld(sz, uns, addr, rd); end
            else begin elat = ((g + 1 > TO) ? g + 1 : TO) + 1; eerr = 1'b1; end
            n_chk++; if (lat !== elat || err !== eerr) begin n_fail++; $display("FAIL rnd%0d_resp: lat %0d err %b want %0d/%b (we %b sz %0d a %h gd %0d rdl %0d)", i, lat, err, elat, eerr, rwe, sz, addr, gd, rdl); end
            n_chk++; if (rdv !== erd) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", i, rdv, erd); end
            n_chk++; if (nreq !== ereq) begin n_fail++; $display("FAIL rnd%0d_nreq: got %0d want %0d", i, nreq, ereq); end
            if (!bad) begin
                n_chk++; if (a !== (addr & 32'hFFFF_FFFC) || be !== m_be(sz, addr) || we !== rwe || st !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_bus: addr %h be %b we %b stable %b want %h/%b/%b/1", i, a, be, we, st, addr & 32'hFFFF_FFFC, m_be(sz, addr), rwe); end
                if (rwe) begin
                    n_chk++; if (w !== m_wd(sz, wd)) begin n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", i, w, m_wd(sz, wd)); end
                end
            end
            @(posedge clk); #1;
            n_chk++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_idle: ready %b resp %b", i, req_ready, resp_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_load();
        test_half_store_delayed();
        test_errors();
        test_timeout();
        test_reset_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
